gpio_pad_ctrl: RTL and testbench

GPIO_PAD_CTRL -- requirements
Module: gpio_pad_ctrl

---
 rtl/gpio_pad_ctrl.sv | 108 ++++++++++
 tb/tb_gpio_pad_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// Single-pin GPIO controller: registered pad drive (push-pull / open-drain), synchronized and filtered input, edge irq.
// Define GPIO_PAD_CTRL_DEBOUNCE_EN to build in the debounce counter; otherwise the input is only synchronized.
module gpio_pad_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic IN_RESET_VAL    = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic o_val,
    input  logic o_oe,
    input  logic od_mode,
    output logic pad_datain,
    output logic pad_oe,
    input  logic pad_dataout,
    output logic in_val,
    output logic rise,
    output logic fall,
    input  logic irq_rise_en,
    input  logic irq_fall_en,
    input  logic irq_clr,
    output logic irq
);

    logic sync1;
    logic sync2;
    logic in_val_q;
    logic irq_set;

    // Open-drain only ever pulls low: a low request enables the driver, a high request releases the pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pad_datain <= 1'b0;
            pad_oe     <= 1'b0;
        end else if (od_mode) begin
            pad_datain <= 1'b0;
            pad_oe     <= ~o_val;
        end else begin
            pad_datain <= o_val;
            pad_oe     <= o_oe;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VAL;
            sync2 <= IN_RESET_VAL;
        end else begin
            sync1 <= pad_dataout;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt;

    // Any cycle where the synchronized level agrees with in_val restarts the stability count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= 8'd0;
            in_val <= IN_RESET_VAL;
        end else if (sync2 == in_val) begin
            cnt <= 8'd0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= 8'd0;
            in_val <= sync2;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^8'(DEBOUNCE_CYCLES);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_val <= IN_RESET_VAL;
        end else begin
            in_val <= sync2;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_val_q <= IN_RESET_VAL;
        end else begin
            in_val_q <= in_val;
        end
    end

    assign rise    = in_val & ~in_val_q;
    assign fall    = ~in_val & in_val_q;
    assign irq_set = (rise & irq_rise_en) | (fall & irq_fall_en);

    // A new edge outranks a clear arriving in the same cycle so no event is lost.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (irq_set) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed self-checking bench for gpio_pad_ctrl; expectations follow whichever build
// (GPIO_PAD_CTRL_DEBOUNCE_EN defined or not) is compiled.
module tb_gpio_pad_ctrl;

    localparam int DEB = 4;
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam int   LAT    = 2 + DEB;
    localparam logic DEB_ON = 1'b1;
`else
    localparam int   LAT    = 3;
    localparam logic DEB_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    logic o_val, o_oe, od_mode;
    logic pad_datain, pad_oe, pad_dataout;
    logic in_val, rise, fall;
    logic irq_rise_en, irq_fall_en, irq_clr, irq;

    int check_count = 0;
    int error_count = 0;
    int high_cnt;
    int rise_cnt;

    gpio_pad_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .IN_RESET_VAL(1'b0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .o_val(o_val),
        .o_oe(o_oe),
        .od_mode(od_mode),
        .pad_datain(pad_datain),
        .pad_oe(pad_oe),
        .pad_dataout(pad_dataout),
        .in_val(in_val),
        .rise(rise),
        .fall(fall),
        .irq_rise_en(irq_rise_en),
        .irq_fall_en(irq_fall_en),
        .irq_clr(irq_clr),
        .irq(irq)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ov, input logic oe, input logic od, input logic pad);
        o_val       = ov;
        o_oe        = oe;
        od_mode     = od;
        pad_dataout = pad;
    endtask

    // Inputs change just after a falling edge; outputs are sampled on falling edges.
    task automatic stepCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n     = 1'b0;
        irq_rise_en = 1'b0;
        irq_fall_en = 1'b0;
        irq_clr     = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        stepCycles(2);
        checkOutput("reset_pad_oe", 8'(pad_oe), 8'd0);
        checkOutput("reset_pad_datain", 8'(pad_datain), 8'd0);
        checkOutput("reset_in_val", 8'(in_val), 8'd0);
        checkOutput("reset_irq", 8'(irq), 8'd0);
        checkOutput("reset_rise", 8'(rise), 8'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        reset_n  = 1'b1;
        rise_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            stepCycles(1);
            if (rise) rise_cnt++;
        end
        checkOutput("post_reset_rise_count", 8'(rise_cnt), 8'd0);
        checkOutput("post_reset_in_val", 8'(in_val), 8'd0);

        // Output path modes
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("pp_before_edge_datain", 8'(pad_datain), 8'd0);
        stepCycles(1);
        checkOutput("pp_datain", 8'(pad_datain), 8'd1);
        checkOutput("pp_oe", 8'(pad_oe), 8'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("od_low_datain", 8'(pad_datain), 8'd0);
        checkOutput("od_low_oe", 8'(pad_oe), 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("od_high_datain", 8'(pad_datain), 8'd0);
        checkOutput("od_high_oe", 8'(pad_oe), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycles(1);
        checkOutput("od_ignores_o_oe", 8'(pad_oe), 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(1);
        checkOutput("pp_off_oe", 8'(pad_oe), 8'd0);

        // Clean rising edge and interrupt
        irq_rise_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycles(LAT - 1);
        checkOutput("rise_in_val_early", 8'(in_val), 8'd0);
        checkOutput("rise_pulse_early", 8'(rise), 8'd0);
        stepCycles(1);
        checkOutput("rise_in_val", 8'(in_val), 8'd1);
        checkOutput("rise_pulse", 8'(rise), 8'd1);
        checkOutput("rise_irq_not_yet", 8'(irq), 8'd0);
        stepCycles(1);
        checkOutput("rise_pulse_one_cycle", 8'(rise), 8'd0);
        checkOutput("rise_irq", 8'(irq), 8'd1);
        irq_rise_en = 1'b0;
        stepCycles(1);
        checkOutput("irq_kept_after_en_off", 8'(irq), 8'd1);
        irq_clr = 1'b1;
        stepCycles(1);
        checkOutput("irq_cleared", 8'(irq), 8'd0);
        irq_clr = 1'b0;

        // Return low with fall interrupts disabled
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(LAT + 2);
        checkOutput("fall_in_val", 8'(in_val), 8'd0);
        checkOutput("fall_no_irq", 8'(irq), 8'd0);

        // Three-cycle glitch: filtered out with debounce, followed otherwise
        irq_rise_en = 1'b1;
        high_cnt    = 0;
        rise_cnt    = 0;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, (i < 3) ? 1'b1 : 1'b0);
            stepCycles(1);
            if (in_val) high_cnt++;
            if (rise) rise_cnt++;
        end
        checkOutput("glitch_in_val_high_cycles", 8'(high_cnt), DEB_ON ? 8'd0 : 8'd3);
        checkOutput("glitch_rise_count", 8'(rise_cnt), DEB_ON ? 8'd0 : 8'd1);
        checkOutput("glitch_irq", 8'(irq), DEB_ON ? 8'd0 : 8'd1);
        checkOutput("glitch_in_val_end", 8'(in_val), 8'd0);
        irq_clr = 1'b1;
        stepCycles(1);
        irq_clr = 1'b0;

        // Set/clear collision on a falling edge
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycles(LAT + 1);
        checkOutput("collide_setup_irq", 8'(irq), 8'd1);
        irq_rise_en = 1'b0;
        irq_fall_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycles(LAT);
        checkOutput("collide_fall_pulse", 8'(fall), 8'd1);
        irq_clr = 1'b1;
        stepCycles(1);
        checkOutput("collide_set_wins", 8'(irq), 8'd1);
        checkOutput("collide_fall_one_cycle", 8'(fall), 8'd0);
        stepCycles(1);
        checkOutput("collide_clr_alone", 8'(irq), 8'd0);
        irq_clr     = 1'b0;
        irq_fall_en = 1'b0;

        // Reset asserted mid-filter discards the pending change
        irq_rise_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        stepCycles(2);
        checkOutput("midreset_pre_oe", 8'(pad_oe), 8'd1);
        #2;
        reset_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("async_reset_oe", 8'(pad_oe), 8'd0);
        checkOutput("async_reset_datain", 8'(pad_datain), 8'd0);
        checkOutput("async_reset_in_val", 8'(in_val), 8'd0);
        stepCycles(1);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        high_cnt = 0;
        rise_cnt = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            stepCycles(1);
            if (in_val) high_cnt++;
            if (rise) rise_cnt++;
        end
        checkOutput("midreset_in_val_high", 8'(high_cnt), 8'd0);
        checkOutput("midreset_rise_count", 8'(rise_cnt), 8'd0);
        checkOutput("midreset_irq", 8'(irq), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
